q2_datapath: RTL and testbench

Parametrised, fully synchronous WIDTH-bit datapath for the Q2 CPU, successor to the per-bit slice. It holds accumulator A, index register X, program counter P and status bit S. It drives the data and address buses through explicit output/enable pairs, with no internal tri-states. It also carries a front-panel FSM for boot load of P and for deposit-with-auto-increment. It sits between the control sequencer (register strobes) and the memory/bus fabric.

---
 rtl/q2_pkg.sv | 19 +
 rtl/q2_datapath_frontpanel.sv | 71 +++++++
 rtl/q2_datapath.sv | 146 ++++++++++++++
 tb/tb_q2_datapath.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/q2_pkg.sv
// q2_pkg: shared encodings for the Q2 datapath.
// X source selector codes and front-panel FSM states.
package q2_pkg;

    localparam logic [2:0] XSEL_ONES  = 3'd0;
    localparam logic [2:0] XSEL_ZERO  = 3'd1;
    localparam logic [2:0] XSEL_SHIFT = 3'd2;
    localparam logic [2:0] XSEL_P     = 3'd3;
    localparam logic [2:0] XSEL_DBUS  = 3'd4;

    typedef enum logic [2:0] {
        FP_BOOT,
        FP_IDLE,
        FP_DEP_WR,
        FP_DEP_INC,
        FP_DEP_WAIT
    } fp_state_t;

endpackage

// File: rtl/q2_datapath_frontpanel.sv
// q2_frontpanel: boot load of P and deposit-with-auto-increment sequencing.
// Deposit states exist only when Q2_DEPOSIT_EN is defined; otherwise the
// FSM only steps BOOT -> IDLE and dep is ignored.
module q2_frontpanel
    import q2_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic dep,
    output logic load_sw,
    output logic fp_inc,
    output logic dep_wr,
    output logic dep_active,
    output logic mem_wr,
    output logic fp_busy
);

    fp_state_t state;
    fp_state_t state_next;

`ifdef Q2_DEPOSIT_EN
    logic dep_q;

    // Previous dep level, so a held request is seen as a single rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dep_q <= 1'b0;
        else        dep_q <= dep;
    end
`else
    logic unused_dep;
    assign unused_dep = dep;
`endif

    // State register; reset always returns to BOOT so P is reloaded from sw
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FP_BOOT;
        else        state <= state_next;
    end

    // Next-state: one boot cycle, then a deposit walks WR -> INC -> WAIT
    always_comb begin
        state_next = state;
        case (state)
            FP_BOOT:     state_next = FP_IDLE;
`ifdef Q2_DEPOSIT_EN
            FP_IDLE:     if (dep && !dep_q) state_next = FP_DEP_WR;
            FP_DEP_WR:   state_next = FP_DEP_INC;
            FP_DEP_INC:  state_next = FP_DEP_WAIT;
            FP_DEP_WAIT: if (!dep) state_next = FP_IDLE;
`endif
            default:     state_next = FP_IDLE;
        endcase
    end

    // Outputs decoded from state only; mem_wr drops the moment reset hits
    always_comb begin
        load_sw    = (state == FP_BOOT);
        fp_busy    = (state != FP_IDLE);
        fp_inc     = 1'b0;
        dep_wr     = 1'b0;
        dep_active = 1'b0;
        mem_wr     = 1'b0;
`ifdef Q2_DEPOSIT_EN
        dep_wr     = (state == FP_DEP_WR);
        fp_inc     = (state == FP_DEP_INC);
        dep_active = dep_wr | fp_inc;
        mem_wr     = dep_wr;
`endif
    end

endmodule

// File: rtl/q2_datapath.sv
// q2_datapath: Q2 CPU register datapath (A, X, P, S) with explicit
// value/enable bus drives and a front-panel boot/deposit sequencer.
// Define Q2_DEPOSIT_EN to include the front-panel deposit path.
module q2_datapath
    import q2_pkg::*;
#(
    parameter int               WIDTH = 12,
    parameter logic [WIDTH-1:0] P_RST = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    input  logic             dep,
    input  logic [WIDTH-1:0] ain,
    input  logic             wra,
    input  logic             rda,
    input  logic             wrx,
    input  logic             rdx,
    input  logic [2:0]       xsel,
    input  logic             xshift_in,
    input  logic             wrp,
    input  logic             rdp,
    input  logic             incp,
    input  logic             wrs,
    input  logic             sin,
    input  logic [WIDTH-1:0] dbus_in,
    output logic [WIDTH-1:0] dbus_out,
    output logic             dbus_oe,
    output logic [WIDTH-1:0] abus_out,
    output logic             abus_oe,
    output logic [WIDTH-1:0] aout,
    output logic [WIDTH-1:0] xout,
    output logic [WIDTH-1:0] pout,
    output logic             sout,
    output logic             xshift_out,
    output logic             mem_wr,
    output logic             fp_busy,
    output logic             bus_err
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] p;
    logic             s;
    logic             err;
    logic [WIDTH-1:0] x_src;
    logic [WIDTH-1:0] p_inc;

    logic load_sw, fp_inc, dep_wr, dep_active;
    logic live;
    logic wra_en, rda_en, wrx_en, rdx_en, wrp_en, rdp_en, incp_en, wrs_en;
    logic reg_strobe, err_set, drive_p;

    q2_frontpanel u_fp (
        .clk        (clk),
        .rst_n      (rst_n),
        .dep        (dep),
        .load_sw    (load_sw),
        .fp_inc     (fp_inc),
        .dep_wr     (dep_wr),
        .dep_active (dep_active),
        .mem_wr     (mem_wr),
        .fp_busy    (fp_busy)
    );

    // Sequencer strobes are ignored during the boot cycle
    assign live    = !load_sw;
    assign wra_en  = live & wra;
    assign rda_en  = live & rda;
    assign wrx_en  = live & wrx;
    assign rdx_en  = live & rdx;
    assign wrp_en  = live & wrp;
    assign rdp_en  = live & rdp;
    assign incp_en = live & incp;
    assign wrs_en  = live & wrs;

    assign reg_strobe = wra_en | wrx_en | wrp_en | incp_en | wrs_en;
    assign err_set    = (rdp_en & rdx_en) | (rda_en & dep_wr) | (reg_strobe & dep_active);
    assign p_inc      = p + {{(WIDTH-1){1'b0}}, 1'b1};

    // X source mux; codes 5-7 leave X unchanged
    always_comb begin
        x_src = x;
        case (xsel)
            XSEL_ONES:  x_src = '1;
            XSEL_ZERO:  x_src = '0;
            XSEL_SHIFT: x_src = {x[WIDTH-2:0], xshift_in};
            XSEL_P:     x_src = p;
            XSEL_DBUS:  x_src = dbus_in;
            default:    x_src = x;
        endcase
    end

    // Accumulator load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      a <= '0;
        else if (wra_en) a <= ain;
    end

    // X load; reads the old P when P changes in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      x <= '0;
        else if (wrx_en) x <= x_src;
    end

    // P: boot load from switches, then wrp > incp > front-panel increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                p <= P_RST;
        else if (load_sw)          p <= sw;
        else if (wrp_en)           p <= x;
        else if (incp_en | fp_inc) p <= p_inc;
    end

    // Status bit load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      s <= 1'b0;
        else if (wrs_en) s <= sin;
    end

    // Sticky contention flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       err <= 1'b0;
        else if (err_set) err <= 1'b1;
    end

    // Data bus: a deposit drives the switch word, otherwise rda drives A
`ifdef Q2_DEPOSIT_EN
    assign dbus_out = dep_wr ? sw : (rda_en ? a : '0);
`else
    assign dbus_out = rda_en ? a : '0;
`endif
    assign dbus_oe  = rda_en | dep_wr;

    // Address bus: P wins over X; a deposit addresses memory with P
    assign drive_p  = rdp_en | dep_wr;
    assign abus_out = drive_p ? p : (rdx_en ? x : '0);
    assign abus_oe  = drive_p | rdx_en;

    assign aout       = a;
    assign xout       = x;
    assign pout       = p;
    assign sout       = s;
    assign xshift_out = x[WIDTH-1];
    assign bus_err    = err;

endmodule

// File: tb/tb_q2_datapath.sv
// tb_q2_datapath: randomized and directed stimulus for q2_datapath, checked
// cycle by cycle against a behavioural model through an expectation queue.
module tb_q2_datapath;

    localparam int W    = 12;
    localparam int MOD  = 1 << W;
    localparam int MASK = MOD - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  sw = '0, ain = '0, dbus_in = '0;
    logic          dep = 0, wra = 0, rda = 0, wrx = 0, rdx = 0;
    logic [2:0]    xsel = '0;
    logic          xshift_in = 0, wrp = 0, rdp = 0, incp = 0, wrs = 0, sin = 0;
    logic [W-1:0]  dbus_out, abus_out, aout, xout, pout;
    logic          dbus_oe, abus_oe, sout, xshift_out, mem_wr, fp_busy, bus_err;

    q2_datapath #(.WIDTH(W), .P_RST('0)) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .dep(dep), .ain(ain),
        .wra(wra), .rda(rda), .wrx(wrx), .rdx(rdx), .xsel(xsel),
        .xshift_in(xshift_in), .wrp(wrp), .rdp(rdp), .incp(incp),
        .wrs(wrs), .sin(sin), .dbus_in(dbus_in),
        .dbus_out(dbus_out), .dbus_oe(dbus_oe),
        .abus_out(abus_out), .abus_oe(abus_oe),
        .aout(aout), .xout(xout), .pout(pout), .sout(sout),
        .xshift_out(xshift_out), .mem_wr(mem_wr), .fp_busy(fp_busy),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a, x, p, s, xso, db, dboe, ab, aboe, mw, busy, err;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   nchk = 0;
    int   npass = 0;

    // Model state: registers, boot flag, deposit phase (0 idle, 1 write, 2 inc, 3 wait)
    int m_a, m_x, m_p, m_s, m_err, m_phase;
    bit m_boot, m_dep_prev;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        nchk++;
        if (got === want) npass++;
        else $display("FAIL %s: got %0o expected %0o at %0t", nm, got, want, $time);
    endtask

    task automatic model_reset();
        m_a = 0; m_x = 0; m_p = 0; m_s = 0; m_err = 0;
        m_phase = 0; m_boot = 1; m_dep_prev = 0;
    endtask

    task automatic clr();
        wra = 0; rda = 0; wrx = 0; rdx = 0; wrp = 0; rdp = 0;
        incp = 0; wrs = 0; xsel = 3'd7; xshift_in = 0;
    endtask

    // Predict this cycle's outputs, queue them, then advance the model one clock
    task automatic tick();
        exp_t e;
        bit   live, ph_wr, ph_inc, any_wr;
        int   nx, np;
        if (!rst_n) model_reset();
        live   = !m_boot;
        ph_wr  = (m_phase == 1);
        ph_inc = (m_phase == 2);
        e.a = m_a; e.x = m_x; e.p = m_p; e.s = m_s;
        e.xso  = (m_x >> (W - 1)) & 1;
        e.dboe = int'((live && rda) || ph_wr);
        e.db   = ph_wr ? int'(sw) : m_a;
        e.aboe = int'((live && (rdp || rdx)) || ph_wr);
        e.ab   = (ph_wr || (live && rdp)) ? m_p : m_x;
        e.mw   = int'(ph_wr);
        e.busy = int'(m_boot || m_phase != 0);
        e.err  = m_err;
        q.push_back(e);
        if (rst_n) begin
            if (m_boot) begin
                m_p = int'(sw);
                m_boot = 0;
            end else begin
                any_wr = wra || wrx || wrp || incp || wrs;
                if ((rdp && rdx) || (rda && ph_wr) || (any_wr && (ph_wr || ph_inc))) m_err = 1;
                nx = m_x;
                if (wrx) begin
                    case (int'(xsel))
                        0:       nx = MASK;
                        1:       nx = 0;
                        2:       nx = (m_x * 2 + int'(xshift_in)) % MOD;
                        3:       nx = m_p;
                        4:       nx = int'(dbus_in);
                        default: nx = m_x;
                    endcase
                end
                np = m_p;
                if (wrp) np = m_x;
                else if (incp || ph_inc) np = (m_p + 1) % MOD;
                if (wra) m_a = int'(ain);
                if (wrs) m_s = int'(sin);
                m_x = nx;
                m_p = np;
`ifdef Q2_DEPOSIT_EN
                case (m_phase)
                    0: if (dep && !m_dep_prev) m_phase = 1;
                    1: m_phase = 2;
                    2: m_phase = 3;
                    default: if (!dep) m_phase = 0;
                endcase
`endif
            end
            m_dep_prev = dep;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare DUT outputs against the oldest expectation each cycle
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                me = q.pop_front();
                chk("aout", aout, me.a);
                chk("xout", xout, me.x);
                chk("pout", pout, me.p);
                chk("sout", sout, me.s);
                chk("xshift_out", xshift_out, me.xso);
                chk("dbus_oe", dbus_oe, me.dboe);
                chk("abus_oe", abus_oe, me.aboe);
                chk("mem_wr", mem_wr, me.mw);
                chk("fp_busy", fp_busy, me.busy);
                chk("bus_err", bus_err, me.err);
                if (me.dboe != 0) chk("dbus_out", dbus_out, me.db);
                if (me.aboe != 0) chk("abus_out", abus_out, me.ab);
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        model_reset();
        clr();
        sw = 12'o1234;
        @(posedge clk);
        #1;
        repeat (3) tick();
        rst_n = 1;
        tick();                                        // BOOT: pout=P_RST
        tick();                                        // pout=sw, idle

        clr(); wrx = 1; xsel = 3'd0; tick();           // X=7777
        clr(); wrp = 1; tick();                        // P=7777
        clr(); incp = 1; tick();                       // P wraps to 0
        clr(); wrx = 1; xsel = 3'd4; dbus_in = 12'o0055; tick();
        clr(); wrp = 1; incp = 1; tick();              // P=0055
        clr(); wrx = 1; xsel = 3'd0; tick();
        clr(); wrx = 1; xsel = 3'd2; xshift_in = 1; tick();
        clr(); wrx = 1; xsel = 3'd4; dbus_in = 12'o0100; tick();
        clr(); wrp = 1; tick();                        // P=0100
        clr(); wrx = 1; xsel = 3'd1; tick();
        clr(); wrx = 1; xsel = 3'd3; incp = 1; tick(); // X gets old P
        clr(); wrx = 1; xsel = 3'd6; tick();           // hold
        clr(); wrp = 1; wrx = 1; xsel = 3'd1; tick();  // P gets old X
        clr(); wra = 1; ain = 12'o4321; wrs = 1; sin = 1; tick();
        clr(); rda = 1; rdx = 1; tick();
        clr(); rdp = 1; rdx = 1; tick();               // contention
        clr(); repeat (3) tick();                      // bus_err sticky

        rst_n = 0; tick(); rst_n = 1; tick(); tick();
`ifdef Q2_DEPOSIT_EN
        clr(); wrx = 1; xsel = 3'd4; dbus_in = 12'o0200; tick();
        clr(); wrp = 1; tick();
        clr(); sw = 12'o5252; dep = 1;
        repeat (10) tick();
        dep = 0; repeat (3) tick();
        dep = 1; tick();                               // edge registered
        rst_n = 0; sw = 12'o1234; tick();              // reset during DEP_WR
        dep = 0; rst_n = 1; tick(); tick();
`endif
        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            sw        = W'($urandom);
            ain       = W'($urandom);
            dbus_in   = W'($urandom);
            xsel      = 3'($urandom);
            xshift_in = 1'($urandom);
            sin       = 1'($urandom);
            wra       = ($urandom_range(0, 3) == 0);
            wrx       = ($urandom_range(0, 2) == 0);
            wrp       = ($urandom_range(0, 4) == 0);
            incp      = ($urandom_range(0, 3) == 0);
            wrs       = ($urandom_range(0, 3) == 0);
            rda       = ($urandom_range(0, 2) == 0);
            rdp       = ($urandom_range(0, 2) == 0);
            rdx       = rdp ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 4) == 0) dep = ~dep;
            tick();
        end
        rst_n = 1; dep = 0; clr();
        tick(); tick();
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
